// File: rtl/load_store_seq.sv
// load_store_seq
// Multicycle sequencer for the load/store path. When the control unit
// starts a request, this block issues a memory read and/or write, pulses the
// MDR load enable and drives the load-size select. Sub-word stores are done
// as read-modify-write. Misaligned or illegal requests raise a 2-bit
// exception code.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-low reset
//   start           request strobe, sampled only in IDLE
//   op              000 lw, 001 lh, 010 lb, 100 sw, 101 sh, 110 sb
//   addr            byte address, captured on accept
//   store_data      store operand, captured on accept
//   mem_rdata       memory read data, valid MEM_LAT cycles after mem_rd
//   mem_addr        captured address, held for the whole operation
//   mem_rd, mem_wr  one-cycle memory strobes
//   mem_wdata       write data, nonzero only while mem_wr=1
//   mdr_we          one-cycle MDR load enable for loads
//   load_sel        00 byte, 01 half, 10 word; held from accept onward
//   reg_we          one-cycle register-file write enable for loads
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse
//   exc_code        00 none, 01 misaligned, 10 illegal op; one-cycle pulse
module load_store_seq #(
    parameter int MEM_LAT     = 2,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        mdr_we,
    output logic [1:0]  load_sel,
    output logic        reg_we,
    output logic        busy,
    output logic        done,
    output logic [1:0]  exc_code
);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, CAPTURE, WB, WRITE, EXC
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state, nstate;
    req_t        req;
    logic [31:0] rword;
    logic [3:0]  cnt;
    logic [1:0]  exc_q;
    logic [1:0]  sel_q;

    // Decode of the live request inputs, only meaningful in IDLE.
    logic       in_illegal;
    logic       in_misalign;
    logic [1:0] in_sel;

    // op[1:0]: 00 word, 01 half, 10 byte, 11 illegal; op[2] marks a store.
    always_comb begin
        in_illegal  = (op[1:0] == 2'b11);
        in_misalign = CHECK_ALIGN &&
                      (((op[1:0] == 2'b00) && (addr[1:0] != 2'b00)) ||
                       ((op[1:0] == 2'b01) && addr[0]));
        case (op[1:0])
            2'b00:   in_sel = 2'b10;
            2'b01:   in_sel = 2'b01;
            default: in_sel = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            req   <= '0;
            rword <= '0;
            cnt   <= '0;
            exc_q <= '0;
            sel_q <= '0;
        end else begin
            state <= nstate;
            if (state == IDLE && start) begin
                req   <= '{op: op, addr: addr, data: store_data};
                sel_q <= in_sel;
                exc_q <= in_illegal ? 2'b10 : (in_misalign ? 2'b01 : 2'b00);
            end
            // WAIT spans MEM_LAT-1 cycles so CAPTURE lands MEM_LAT after mem_rd.
            if (state == READ)
                cnt <= LAT_M1;
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (state == CAPTURE)
                rword <= mem_rdata;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (in_illegal || in_misalign)
                        nstate = EXC;
                    else if (op == 3'b100)
                        nstate = WRITE;
                    else
                        nstate = READ;
                end
            end
            READ:    nstate = (MEM_LAT <= 1) ? CAPTURE : WAIT;
            WAIT:    if (cnt <= 4'd1) nstate = CAPTURE;
            CAPTURE: nstate = req.op[2] ? WRITE : WB;
            WB:      nstate = IDLE;
            WRITE:   nstate = IDLE;
            EXC:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state == READ);
        mem_wr    = (state == WRITE);
        mdr_we    = (state == CAPTURE) && !req.op[2];
        reg_we    = (state == WB);
        done      = (state == WB) || (state == WRITE);
        busy      = (state != IDLE);
        exc_code  = (state == EXC) ? exc_q : 2'b00;
        mem_addr  = req.addr;
        load_sel  = sel_q;
        mem_wdata = '0;
        if (state == WRITE) begin
            case (req.op[1:0])
                2'b00:   mem_wdata = req.data;
                2'b01:   mem_wdata = {rword[31:16], req.data[15:0]};
                2'b10:   mem_wdata = {rword[31:8], req.data[7:0]};
                default: mem_wdata = '0;
            endcase
        end
    end

    // The low byte of the read word is always overwritten by a store.
    logic unused_rword;
    assign unused_rword = ^rword[7:0];

endmodule

// File: tb/tb_load_store_seq.sv
module tb_load_store_seq;

    localparam int L = 2;

    typedef struct {
        int          cyc;
        logic [5:0]  strb;   // rd, wr, mdr_we, reg_we, done, exc!=0
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  sel;
        logic        csel;
        logic [1:0]  exc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset, start1, start2;
    logic [2:0]  op;
    logic [31:0] addr, sd, rdata;

    logic [31:0] a1, wd1, a2, wd2;
    logic        rd1, wr1, mdr1, rwe1, busy1, done1;
    logic        rd2, wr2, mdr2, rwe2, busy2, done2;
    logic [1:0]  sel1, exc1, sel2, exc2;

    load_store_seq #(.MEM_LAT(L), .CHECK_ALIGN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .addr(addr),
        .store_data(sd), .mem_rdata(rdata), .mem_addr(a1), .mem_rd(rd1),
        .mem_wr(wr1), .mem_wdata(wd1), .mdr_we(mdr1), .load_sel(sel1),
        .reg_we(rwe1), .busy(busy1), .done(done1), .exc_code(exc1));

    load_store_seq #(.MEM_LAT(L), .CHECK_ALIGN(1'b0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .op(op), .addr(addr),
        .store_data(sd), .mem_rdata(rdata), .mem_addr(a2), .mem_rd(rd2),
        .mem_wr(wr2), .mem_wdata(wd2), .mdr_we(mdr2), .load_sel(sel2),
        .reg_we(rwe2), .busy(busy2), .done(done2), .exc_code(exc2));

    ev_t q1[$];
    ev_t q2[$];
    int  errors = 0;
    int  checks = 0;
    logic tmo, chk_rst, chk_idle;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit d2, input ev_t e);
        if (d2) q2.push_back(e);
        else    q1.push_back(e);
    endtask

    // Expected strobe timeline for one request accepted in cycle t0.
    task automatic push(input bit d2, input logic [2:0] o, input logic [31:0] a,
                        input int t0, input logic [1:0] sel, input logic [1:0] exc,
                        input logic [31:0] wd, input bit csel, input bit rd_only);
        ev_t e;
        e.addr = a; e.sel = sel; e.csel = csel; e.exc = 2'b00; e.wd = wd;
        if (exc != 2'b00) begin
            e.cyc = t0 + 1; e.strb = 6'b000001; e.exc = exc; add(d2, e);
        end else if (o == 3'b100) begin
            e.cyc = t0 + 1; e.strb = 6'b010010; add(d2, e);
        end else begin
            e.cyc = t0 + 1; e.strb = 6'b100000; add(d2, e);
            if (!rd_only) begin
                if (!o[2]) begin
                    e.cyc = t0 + 1 + L; e.strb = 6'b001000; add(d2, e);
                    e.cyc = t0 + 2 + L; e.strb = 6'b000110; add(d2, e);
                end else begin
                    e.cyc = t0 + 2 + L; e.strb = 6'b010010; add(d2, e);
                end
            end
        end
    endtask

    task automatic check_ev(input bit d2, input logic [5:0] g, input logic [31:0] ad,
                            input logic [31:0] wd, input logic [1:0] sel,
                            input logic [1:0] exc);
        ev_t e;
        if ((d2 && q2.size() == 0) || (!d2 && q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe dut%0d cyc=%0d got strb=%b", d2 + 1, cyc, g);
        end else begin
            if (d2) e = q2.pop_front();
            else    e = q1.pop_front();
            checks++;
            if (e.cyc != cyc || e.strb != g) begin
                errors++;
                $display("FAIL strobe dut%0d: got strb=%b cyc=%0d, want strb=%b cyc=%0d",
                         d2 + 1, g, cyc, e.strb, e.cyc);
            end
            checks++;
            if (ad != e.addr) begin
                errors++;
                $display("FAIL mem_addr dut%0d cyc=%0d: got %h want %h", d2 + 1, cyc, ad, e.addr);
            end
            checks++;
            if (exc != e.exc) begin
                errors++;
                $display("FAIL exc_code dut%0d cyc=%0d: got %b want %b", d2 + 1, cyc, exc, e.exc);
            end
            if (e.csel) begin
                checks++;
                if (sel != e.sel) begin
                    errors++;
                    $display("FAIL load_sel dut%0d cyc=%0d: got %b want %b", d2 + 1, cyc, sel, e.sel);
                end
            end
            if (e.strb[4]) begin
                checks++;
                if (wd != e.wd) begin
                    errors++;
                    $display("FAIL mem_wdata dut%0d cyc=%0d: got %h want %h", d2 + 1, cyc, wd, e.wd);
                end
            end
        end
    endtask

    // Monitor: samples both DUTs on the falling edge.
    always @(negedge clk) begin
        logic [5:0] g1, g2;
        g1 = {rd1, wr1, mdr1, rwe1, done1, exc1 != 2'b00};
        g2 = {rd2, wr2, mdr2, rwe2, done2, exc2 != 2'b00};
        if (tmo) begin
            checks++; errors++;
            $display("FAIL timeout: pending dut1=%0d dut2=%0d want 0", q1.size(), q2.size());
            q1.delete(); q2.delete();
        end
        if (chk_rst) begin
            checks++;
            if ({g1, busy1, exc1, sel1} != '0 || a1 != '0 || wd1 != '0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d: strb=%b busy=%b sel=%b addr=%h wdata=%h want all 0",
                         cyc, g1, busy1, sel1, a1, wd1);
            end
        end
        if (chk_idle) begin
            checks++;
            if (busy1 || g1 != '0) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d: busy=%b strb=%b want 0", cyc, busy1, g1);
            end
        end
        if (g1 != '0) check_ev(1'b0, g1, a1, wd1, sel1, exc1);
        if (g2 != '0) check_ev(1'b1, g2, a2, wd2, sel2, exc2);
    end

    task automatic wait_empty;
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 40) begin
            step; n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            tmo = 1'b1; step; tmo = 1'b0;
        end
        step; step;
    endtask

    // One request; inputs are scrambled right after accept.
    task automatic run(input bit d2, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] s, input logic [31:0] rw,
                       input logic [1:0] sel, input logic [1:0] exc,
                       input logic [31:0] wd, input bit csel);
        step;
        if (d2) start2 = 1'b1; else start1 = 1'b1;
        op = o; addr = a; sd = s; rdata = rw;
        push(d2, o, a, cyc, sel, exc, wd, csel, 1'b0);
        step;
        start1 = 1'b0; start2 = 1'b0;
        op = 3'b010; addr = ~a; sd = ~s;
        wait_empty;
    endtask

    initial begin
        int t0;
        reset = 1'b0; start1 = 1'b1; start2 = 1'b0; op = 3'b000;
        addr = '0; sd = '0; rdata = '0;
        tmo = 1'b0; chk_rst = 1'b0; chk_idle = 1'b0;
        step; chk_rst = 1'b1;
        step; step;
        reset = 1'b1; start1 = 1'b0; chk_rst = 1'b0;
        step; step;

        run(0, 3'b000, 32'h10, 32'h0,        32'hDEADBEEF, 2'b10, 2'b00, 32'h0,        1'b1);
        run(0, 3'b110, 32'h21, 32'hAA,       32'h11223344, 2'b00, 2'b00, 32'h112233AA, 1'b1);
        run(0, 3'b100, 32'h8,  32'hCAFEF00D, 32'h0,        2'b10, 2'b00, 32'hCAFEF00D, 1'b1);
        run(0, 3'b101, 32'h6,  32'h1234,     32'hFFFFFFFF, 2'b01, 2'b00, 32'hFFFF1234, 1'b1);
        run(0, 3'b110, 32'h33, 32'h3C,       32'hA5A5A5A5, 2'b00, 2'b00, 32'hA5A5A53C, 1'b1);
        run(0, 3'b010, 32'h3,  32'h0,        32'h0BADF00D, 2'b00, 2'b00, 32'h0,        1'b1);
        run(0, 3'b000, 32'h2,  32'h0,        32'h0,        2'b10, 2'b01, 32'h0,        1'b1);
        run(0, 3'b001, 32'h3,  32'h0,        32'h0,        2'b01, 2'b01, 32'h0,        1'b1);
        run(0, 3'b101, 32'h1,  32'h0,        32'h0,        2'b01, 2'b01, 32'h0,        1'b1);
        run(0, 3'b100, 32'h6,  32'h0,        32'h0,        2'b10, 2'b01, 32'h0,        1'b1);
        run(0, 3'b111, 32'h2,  32'h0,        32'h0,        2'b00, 2'b10, 32'h0,        1'b0);
        run(0, 3'b011, 32'h4,  32'h0,        32'h0,        2'b00, 2'b10, 32'h0,        1'b0);
        run(1, 3'b001, 32'h3,  32'h0,        32'h55667788, 2'b01, 2'b00, 32'h0,        1'b1);

        // Start pulse during WAIT of a load must be ignored.
        step; start1 = 1'b1; op = 3'b000; addr = 32'h40; rdata = 32'h01020304;
        push(0, 3'b000, 32'h40, cyc, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0);
        step; start1 = 1'b0;
        step; start1 = 1'b1; op = 3'b100; addr = 32'h80; sd = 32'h1;
        step; start1 = 1'b0;
        wait_empty;

        // Start held high: ignored while busy, lb accepted the cycle after done.
        step; start1 = 1'b1; op = 3'b000; addr = 32'h14; rdata = 32'h89ABCDEF;
        t0 = cyc;
        push(0, 3'b000, 32'h14, t0, 2'b10, 2'b00, 32'h0, 1'b1, 1'b0);
        push(0, 3'b010, 32'h15, t0 + 3 + L, 2'b00, 2'b00, 32'h0, 1'b1, 1'b0);
        step; op = 3'b010; addr = 32'h15;
        for (int i = 0; i < L + 3; i++) step;
        start1 = 1'b0;
        wait_empty;

        // Reset during WAIT of an sh: back to IDLE, no write ever.
        step; start1 = 1'b1; op = 3'b101; addr = 32'h22; sd = 32'h5555; rdata = 32'h0;
        push(0, 3'b101, 32'h22, cyc, 2'b01, 2'b00, 32'h0, 1'b1, 1'b1);
        step; start1 = 1'b0;
        step; reset = 1'b0;
        step; reset = 1'b1; chk_idle = 1'b1;
        for (int i = 0; i < 4; i++) step;
        chk_idle = 1'b0;
        wait_empty;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_seq.md
Name: load_store_seq

Overview:
- Multicycle sequencer for the load/store path.
- On a request from the main control unit it issues memory reads and writes with a fixed read latency, strobes the MDR write enable, and drives the 2-bit load-size select (00 byte, 01 half, 10 word) into the load-size unit.
- Performs read-modify-write for sub-word stores and flags misaligned or illegal requests on a 2-bit exception code.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the mem_rd cycle to valid mem_rdata (legal 1..15)
- CHECK_ALIGN, 1, 1 = raise a misalignment exception, 0 = ignore address low bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  request strobe; sampled only in IDLE
- op  input  3  000 lw, 001 lh, 010 lb, 100 sw, 101 sh, 110 sb; 011 and 111 illegal
- addr  input  32  byte address, captured on accept
- store_data  input  32  store operand, captured on accept
- mem_rdata  input  32  memory read data
- mem_addr  output  32  registered address, held for the whole operation
- mem_rd  output  1  one-cycle read strobe
- mem_wr  output  1  one-cycle write strobe
- mem_wdata  output  32  write data, valid when mem_wr=1
- mdr_we  output  1  one-cycle MDR load enable
- load_sel  output  2  size select for the load-size unit, held from accept until return to IDLE
- reg_we  output  1  one-cycle register-file write enable for loads
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- exc_code  output  2  00 none, 01 misaligned, 10 illegal op; pulsed for one cycle

Behaviour:
- Reset: with reset=0 at a clk edge, state=IDLE and every output is 0 (load_sel=00, mem_addr=0, mem_wdata=0). A reset in any state aborts the operation; no mem_wr is issued after that edge.
- States: IDLE, READ, WAIT, CAPTURE, WB, WRITE, EXC.
- IDLE, start=1:
  - Capture op, addr and store_data.
  - Set load_sel: lw/sw → 10, lh/sh → 01, lb/sb → 00.
  - Exception check, in priority order: illegal op → EXC with code 10. Otherwise, if CHECK_ALIGN=1 and (lw/sw with addr[1:0]≠0, or lh/sh with addr[0]=1) → EXC with code 01.
  - Otherwise sw → WRITE; any other op → READ.
- Request handling:
  - start is ignored while busy.
  - The start cycle itself is T0.
- READ (1 cycle): mem_rd=1 → WAIT.
- WAIT: an internal counter runs from MEM_LAT-1 down to 1, then → CAPTURE. With MEM_LAT=1, WAIT is skipped and READ goes straight to CAPTURE.
- CAPTURE (1 cycle): occurs exactly MEM_LAT cycles after mem_rd.
  - Sample mem_rdata into an internal word register.
  - Loads: mdr_we=1 → WB.
  - sb/sh: mdr_we=0 → WRITE.
- WB (1 cycle): reg_we=1, done=1 → IDLE. load_sel stays valid through WB.
- WRITE (1 cycle): mem_wr=1, done=1 → IDLE.
  - sw: mem_wdata = store_data.
  - sh: mem_wdata = {rword[31:16], store_data[15:0]}.
  - sb: mem_wdata = {rword[31:8], store_data[7:0]}.
- EXC (1 cycle): exc_code driven; done=0, no memory strobe → IDLE.
- Latency:
  - Loads: done at T(2+MEM_LAT).
  - sw: done at T1.
  - sb/sh: done at T(2+MEM_LAT).
  - Exceptions: exc_code at T1.
- Back-to-back: a start held high in the cycle after done is accepted the following cycle, since IDLE lasts at least one cycle.
- Strobe exclusivity: mem_rd, mem_wr, mdr_we, reg_we, done and a nonzero exc_code are each a single cycle. mem_rd and mem_wr are never high together.
- Operand stability: mem_addr and load_sel are stable from T1 to the done/EXC cycle, independent of input changes after accept.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 and op=000 → all outputs 0, busy=0, no mem_rd.
- lw, MEM_LAT=2: addr=0x10, mem_rdata=0xDEADBEEF valid at T3 → mem_rd at T1, mdr_we at T3, reg_we and done at T4, load_sel=10, mem_addr=0x10 throughout.
- sb RMW: addr=0x21, store_data=0x000000AA, memory word 0x11223344 → mem_rd at T1, mem_wr and done at T4 with mem_wdata=0x112233AA, exc_code=00.
- sw and sh: sw at addr=0x8 with store_data=0xCAFEF00D → mem_wr at T1. sh with read word 0xFFFFFFFF and store_data=0x00001234 → mem_wdata=0xFFFF1234.
- Exceptions: lw at addr=0x2 → exc_code=01 at T1, no strobes, no done. op=111 at addr=0x2 → exc_code=10 (illegal takes priority). With CHECK_ALIGN=0, lh at addr=0x3 completes normally.
- Abort and busy: assert reset=0 during WAIT of an sh → IDLE next cycle, no mem_wr ever. A start pulse while busy is ignored. A back-to-back lb after a completed lw is accepted.
